// File: rtl/dm_access_unit.sv
// ---------------------------------------------------------------------------
// dm_access_unit
//
// Load/store initiator between the MIPS execute stage and a word-indexed
// data memory. Accepts one byte, halfword or word request at a time,
// converts the byte address into a word index, holds dm_memread for
// READ_WAIT cycles before sampling read data, performs sub-word stores as
// read-modify-write and returns loads sign- or zero-extended.
//
// Parameters
//   READ_WAIT     cycles dm_memread is held before read data is sampled (>=1)
//   ADDR_BITS     word-index width of the data memory
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   req_valid     request present
//   req_ready     unit idle; request accepted on a clk edge with req_valid=1
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle completion pulse
//   resp_rdata    load result (0 for stores and errors)
//   resp_error    misaligned or illegal-size request
//   dm_read_adr   word index for reads, zero-extended
//   dm_write_adr  word index for writes, zero-extended
//   dm_write_data full word to write
//   dm_memread    read enable
//   dm_memwrite   write enable, memory commits on the clk edge
//   dm_read_data  memory read data
// ---------------------------------------------------------------------------
module dm_access_unit #(
    parameter int READ_WAIT = 1,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] dm_read_adr,
    output logic [31:0] dm_write_adr,
    output logic [31:0] dm_write_data,
    output logic        dm_memread,
    output logic        dm_memwrite,
    input  logic [31:0] dm_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_WAIT - 1);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    state_t               state_q;
    logic [CNT_W-1:0]     waitCnt_q;
    logic [ADDR_BITS+1:0] addr_q;
    logic [1:0]           size_q;
    logic                 unsigned_q;
    logic                 write_q;
    logic [31:0]          wdata_q;
    logic [31:0]          readWord_q;
    logic [31:0]          rdata_q;
    logic                 error_q;

    logic        reqAccept;
    logic        reqError;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;
    logic [31:0] wordIndex;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Address bits above the memory's word index are deliberately ignored.
    logic addr_unused;
    assign addr_unused = ^req_addr[31:ADDR_BITS+2];

    assign reqAccept = req_ready && req_valid;

    // Illegal size, odd halfword or non-word-aligned word requests never
    // touch memory.
    assign reqError = (req_size == SIZE_ILL)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

    assign wordIndex = {{(32-ADDR_BITS){1'b0}}, addr_q[ADDR_BITS+1:2]};

    // Lane selection and extension applied to the word arriving from memory,
    // so the load result can be registered on the sampling edge.
    always_comb begin
        loadByte = dm_read_data[{addr_q[1:0], 3'b000} +: 8];
        loadHalf = addr_q[1] ? dm_read_data[31:16] : dm_read_data[15:0];
        case (size_q)
            SIZE_BYTE: loadValue = unsigned_q ? {24'h0, loadByte}
                                              : {{24{loadByte[7]}}, loadByte};
            SIZE_HALF: loadValue = unsigned_q ? {16'h0, loadHalf}
                                              : {{16{loadHalf[15]}}, loadHalf};
            default:   loadValue = dm_read_data;
        endcase
    end

    // Read-modify-write merge: the sampled word with only the target lane
    // replaced by the right-aligned store data.
    always_comb begin
        mergedWord = readWord_q;
        if (size_q == SIZE_BYTE) begin
            mergedWord[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            mergedWord[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Main sequencer. Errors go straight to RESP, word stores skip the read,
    // loads and sub-word stores pass through RD for READ_WAIT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            readWord_q <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqAccept) begin
                        addr_q     <= req_addr[ADDR_BITS+1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata;
                        rdata_q    <= '0;
                        error_q    <= reqError;
                        waitCnt_q  <= CNT_INIT;
                        if (reqError) begin
                            state_q <= RESP;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (waitCnt_q == '0) begin
                        readWord_q <= dm_read_data;
                        if (write_q) begin
                            state_q <= WR;
                        end else begin
                            rdata_q <= loadValue;
                            state_q <= RESP;
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q - CNT_W'(1);
                    end
                end
                WR: begin
                    state_q <= RESP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = (state_q == RESP) ? rdata_q : 32'h0;
    assign resp_error    = (state_q == RESP) && error_q;
    assign dm_memread    = (state_q == RD);
    assign dm_memwrite   = (state_q == WR);
    assign dm_read_adr   = (state_q == RD) ? wordIndex : 32'h0;
    assign dm_write_adr  = (state_q == WR) ? wordIndex : 32'h0;
    assign dm_write_data = (state_q != WR)        ? 32'h0 :
                           (size_q == SIZE_WORD)  ? wdata_q : mergedWord;

endmodule

// File: tb/tb_dm_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dm_access_unit
//
// Two instances share one behavioural memory (word i preloaded with i):
// dutA uses READ_WAIT=1, dutB uses READ_WAIT=3. Expected responses are
// pushed to a scoreboard queue when a request is driven and popped when the
// selected instance raises resp_valid.
// ---------------------------------------------------------------------------
module tb_dm_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        reqValidA, reqValidB;
    logic        reqWrite, reqUnsigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWdata;

    logic        readyA, respValidA, errA, memreadA, memwriteA;
    logic [31:0] rdataA, rdAdrA, wrAdrA, wrDataA, rdDataA;
    logic        readyB, respValidB, errB, memreadB, memwriteB;
    logic [31:0] rdataB, rdAdrB, wrAdrB, wrDataB, rdDataB;

    dm_access_unit #(.READ_WAIT(1), .ADDR_BITS(8)) dutA (
        .clk(clk), .reset(reset),
        .req_valid(reqValidA), .req_ready(readyA), .req_write(reqWrite),
        .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr),
        .req_wdata(reqWdata), .resp_valid(respValidA), .resp_rdata(rdataA),
        .resp_error(errA), .dm_read_adr(rdAdrA), .dm_write_adr(wrAdrA),
        .dm_write_data(wrDataA), .dm_memread(memreadA), .dm_memwrite(memwriteA),
        .dm_read_data(rdDataA)
    );

    dm_access_unit #(.READ_WAIT(3), .ADDR_BITS(8)) dutB (
        .clk(clk), .reset(reset),
        .req_valid(reqValidB), .req_ready(readyB), .req_write(reqWrite),
        .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr),
        .req_wdata(reqWdata), .resp_valid(respValidB), .resp_rdata(rdataB),
        .resp_error(errB), .dm_read_adr(rdAdrB), .dm_write_adr(wrAdrB),
        .dm_write_data(wrDataB), .dm_memread(memreadB), .dm_memwrite(memwriteB),
        .dm_read_data(rdDataB)
    );

    // Behavioural data memory: combinational read, write on the clk edge.
    logic [31:0] mem [256];
    logic        loadMem;

    assign rdDataA = mem[rdAdrA[7:0]];
    assign rdDataB = mem[rdAdrB[7:0]];

    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
        end else begin
            if (memwriteA) mem[wrAdrA[7:0]] <= wrDataA;
            if (memwriteB) mem[wrAdrB[7:0]] <= wrDataB;
        end
    end

    // Output view of whichever instance is currently under test.
    logic        sel;
    logic        selReady, selRespValid, selErr, selMemread, selMemwrite;
    logic [31:0] selRdata, selRdAdr, selWrAdr, selWrData;

    always_comb begin
        selReady     = sel ? readyB     : readyA;
        selRespValid = sel ? respValidB : respValidA;
        selErr       = sel ? errB       : errA;
        selMemread   = sel ? memreadB   : memreadA;
        selMemwrite  = sel ? memwriteB  : memwriteA;
        selRdata     = sel ? rdataB     : rdataA;
        selRdAdr     = sel ? rdAdrB     : rdAdrA;
        selWrAdr     = sel ? wrAdrB     : wrAdrA;
        selWrData    = sel ? wrDataB    : wrDataA;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request to the selected instance, follow it to completion
    // and compare the response against the scoreboard plus memory traffic.
    task automatic applyStimulus(input string tag, input bit useB, input bit wr,
                                 input logic [1:0] sz, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input bit expErr,
                                 input int expLat, input int expReads,
                                 input int expWrites, input logic [31:0] expWrData);
        int          cycles, reads, writes, badAdr, both;
        bit          got;
        logic [31:0] wrAdrSeen, wrDataSeen, idx;
        exp_t        e;
        idx = {24'h0, addr[9:2]};
        @(negedge clk);
        sel         = useB;
        reqWrite    = wr;
        reqSize     = sz;
        reqUnsigned = uns;
        reqAddr     = addr;
        reqWdata    = wdata;
        reqValidA   = !useB;
        reqValidB   = useB;
        checkOutput({tag, ".ready"}, {31'h0, selReady}, 32'h1);
        sbQ.push_back('{expRdata, expErr, expLat});
        @(posedge clk);
        #1;
        reqValidA = 1'b0;
        reqValidB = 1'b0;
        cycles = 0; reads = 0; writes = 0; badAdr = 0; both = 0; got = 1'b0;
        wrAdrSeen = 32'h0; wrDataSeen = 32'h0;
        while (cycles < 40 && !got) begin
            cycles++;
            if (selMemread) begin
                reads++;
                if (selRdAdr !== idx) badAdr++;
            end
            if (selMemwrite) begin
                writes++;
                wrAdrSeen  = selWrAdr;
                wrDataSeen = selWrData;
            end
            if (selMemread && selMemwrite) both++;
            if (selRespValid) begin
                got = 1'b1;
                e = sbQ.pop_front();
                checkOutput({tag, ".lat"},   cycles,            e.lat);
                checkOutput({tag, ".rdata"}, selRdata,          e.rdata);
                checkOutput({tag, ".err"},   {31'h0, selErr},   {31'h0, e.err});
            end else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput({tag, ".respSeen"}, {31'h0, got}, 32'h1);
        if (!got && sbQ.size() > 0) void'(sbQ.pop_front());
        checkOutput({tag, ".reads"},  reads,  expReads);
        checkOutput({tag, ".writes"}, writes, expWrites);
        checkOutput({tag, ".rdAdr"},  badAdr, 0);
        checkOutput({tag, ".rdWrOverlap"}, both, 0);
        if (expWrites > 0) begin
            checkOutput({tag, ".wrAdr"},  wrAdrSeen,  idx);
            checkOutput({tag, ".wrData"}, wrDataSeen, expWrData);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".readyAfter"}, {31'h0, selReady}, 32'h1);
        checkOutput({tag, ".pulseOnce"},  {31'h0, selRespValid}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int noResp;
        sel = 1'b0; reset = 1'b0; loadMem = 1'b1;
        reqValidA = 1'b0; reqValidB = 1'b0; reqWrite = 1'b0; reqUnsigned = 1'b0;
        reqSize = 2'b00; reqAddr = 32'h0; reqWdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        loadMem = 1'b0;
        checkOutput("rst.ready",     {31'h0, readyA},     32'h1);
        checkOutput("rst.respValid", {31'h0, respValidA}, 32'h0);
        checkOutput("rst.rdata",     rdataA,              32'h0);
        checkOutput("rst.err",       {31'h0, errA},       32'h0);
        checkOutput("rst.memread",   {31'h0, memreadA},   32'h0);
        checkOutput("rst.memwrite",  {31'h0, memwriteA},  32'h0);
        checkOutput("rst.rdAdr",     rdAdrA,              32'h0);
        checkOutput("rst.wrData",    wrDataA,             32'h0);
        reset = 1'b1;

        //            tag     B  wr  sz    u  addr          wdata         rdata         err lat rd wr  wrData
        applyStimulus("lw14", 0, 0, 2'b10, 0, 32'h0000_0014, 32'h0,       32'h0000_0005, 0, 2, 1, 0, 32'h0);
        applyStimulus("sb09", 0, 1, 2'b00, 0, 32'h0000_0009, 32'h0000_00AB, 32'h0,      0, 3, 1, 1, 32'h0000_AB02);
        applyStimulus("lb09", 0, 0, 2'b00, 0, 32'h0000_0009, 32'h0,       32'hFFFF_FFAB, 0, 2, 1, 0, 32'h0);
        applyStimulus("lbu09",0, 0, 2'b00, 1, 32'h0000_0009, 32'h0,       32'h0000_00AB, 0, 2, 1, 0, 32'h0);
        applyStimulus("sh0E", 0, 1, 2'b01, 0, 32'h0000_000E, 32'h0000_8001, 32'h0,      0, 3, 1, 1, 32'h8001_0003);
        applyStimulus("lh0E", 0, 0, 2'b01, 0, 32'h0000_000E, 32'h0,       32'hFFFF_8001, 0, 2, 1, 0, 32'h0);
        applyStimulus("lhu0E",0, 0, 2'b01, 1, 32'h0000_000E, 32'h0,       32'h0000_8001, 0, 2, 1, 0, 32'h0);
        applyStimulus("lw0C", 0, 0, 2'b10, 0, 32'h0000_000C, 32'h0,       32'h8001_0003, 0, 2, 1, 0, 32'h0);
        applyStimulus("lwMis",0, 0, 2'b10, 0, 32'h0000_0006, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
        applyStimulus("szIll",0, 0, 2'b11, 0, 32'h0000_0000, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
        applyStimulus("lhMis",0, 0, 2'b01, 0, 32'h0000_0001, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
        applyStimulus("shMis",0, 1, 2'b01, 0, 32'h0000_0003, 32'h0000_1234, 32'h0,      1, 1, 0, 0, 32'h0);
        applyStimulus("sw20", 0, 1, 2'b10, 0, 32'h0000_0020, 32'h1234_5678, 32'h0,      0, 2, 0, 1, 32'h1234_5678);
        applyStimulus("lw20", 0, 0, 2'b10, 0, 32'hF000_0020, 32'h0,       32'h1234_5678, 0, 2, 1, 0, 32'h0);
        applyStimulus("lbu23",0, 0, 2'b00, 1, 32'h0000_0023, 32'h0,       32'h0000_0012, 0, 2, 1, 0, 32'h0);
        applyStimulus("lb21", 0, 0, 2'b00, 0, 32'h0000_0021, 32'h0,       32'h0000_0056, 0, 2, 1, 0, 32'h0);

        // Reset asserted while a word store is in WR, before its commit edge.
        @(negedge clk);
        sel = 1'b0; reqWrite = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0;
        reqAddr = 32'h0000_0010; reqWdata = 32'hDEAD_BEEF; reqValidA = 1'b1;
        @(posedge clk);
        #1;
        reqValidA = 1'b0;
        checkOutput("rstWr.memwriteHigh", {31'h0, memwriteA}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("rstWr.memwriteDrop", {31'h0, memwriteA}, 32'h0);
        checkOutput("rstWr.ready",        {31'h0, readyA},    32'h1);
        noResp = 0;
        for (int i = 0; i < 3; i++) begin
            if (respValidA) noResp++;
            @(posedge clk);
            #1;
        end
        checkOutput("rstWr.noResp", noResp, 0);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("rstWr.mem4", mem[4], 32'h0000_0004);
        applyStimulus("lw10", 0, 0, 2'b10, 0, 32'h0000_0010, 32'h0,       32'h0000_0004, 0, 2, 1, 0, 32'h0);

        // READ_WAIT=3 instance.
        applyStimulus("B.lw14", 1, 0, 2'b10, 0, 32'h0000_0014, 32'h0,     32'h0000_0005, 0, 4, 3, 0, 32'h0);
        applyStimulus("B.sb18", 1, 1, 2'b00, 0, 32'h0000_0018, 32'h0000_017F, 32'h0,    0, 5, 3, 1, 32'h0000_007F);
        applyStimulus("B.lb18", 1, 0, 2'b00, 0, 32'h0000_0018, 32'h0,     32'h0000_007F, 0, 4, 3, 0, 32'h0);
        applyStimulus("B.err",  1, 0, 2'b10, 0, 32'h0000_0002, 32'h0,     32'h0,         1, 1, 0, 0, 32'h0);
        applyStimulus("A.lw18", 0, 0, 2'b10, 0, 32'h0000_0018, 32'h0,     32'h0000_007F, 0, 2, 1, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
